// File: rtl/mem_req_arbiter_if.sv
// Request/response port bundle shared by requesters and downstream memory.
// master drives requests and receives responses; slave is the opposite side.
interface mem_req_arbiter_if;
  logic        rq_valid;
  logic        rq_ready;
  logic [31:0] rq_addr;
  logic        rq_iswrite;
  logic [31:0] rq_data;
  logic        rs_valid;
  logic [31:0] rs_data;

  modport master (
    output rq_valid, rq_addr, rq_iswrite, rq_data,
    input  rq_ready, rs_valid, rs_data
  );

  modport slave (
    input  rq_valid, rq_addr, rq_iswrite, rq_data,
    output rq_ready, rs_valid, rs_data
  );
endinterface

// File: rtl/mem_req_arbiter.sv
// Two-way round-robin memory request arbiter with an in-order owner tag
// FIFO that steers each downstream response back to its requester.
module mem_req_arbiter #(
  parameter int LGINFL = 1
) (
  input  logic              clk,
  input  logic              reset,
  mem_req_arbiter_if.slave  m0,
  mem_req_arbiter_if.slave  m1,
  mem_req_arbiter_if.master ds,
  output logic [LGINFL:0]   inflight,
  output logic              err_unexpected_rs
);
  localparam int DEPTH = 1 << LGINFL;
  localparam int CW = LGINFL + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [DEPTH-1:0]  fifo_q, fifo_d;
  logic [LGINFL-1:0] wptr_q, wptr_d;
  logic [LGINFL-1:0] rptr_q, rptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              last_q, last_d;
  logic              err_q, err_d;

  logic any_rq;
  logic gnt;
  logic can_issue;
  logic rq_vld;
  logic push;
  logic pop;
  logic head;

  always_comb begin
    any_rq = m0.rq_valid | m1.rq_valid;
    // On contention the requester that did not win last time goes next.
    gnt = (m0.rq_valid & m1.rq_valid) ? ~last_q : m1.rq_valid;
    // A response retiring this cycle frees a slot for a new issue.
    can_issue = (count_q < DEPTH_C) | ds.rs_valid;
    rq_vld = any_rq & can_issue;
    push = rq_vld & ds.rq_ready;
    pop = ds.rs_valid & (count_q != '0);
    head = fifo_q[rptr_q];
  end

  always_comb begin
    fifo_d = fifo_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    count_d = count_q;
    last_d = last_q;
    err_d = err_q;
    if (push) begin
      fifo_d[wptr_q] = gnt;
      wptr_d = wptr_q + LGINFL'(1);
      last_d = gnt;
    end
    if (pop) begin
      rptr_d = rptr_q + LGINFL'(1);
    end
    if (ds.rs_valid & ~pop) begin
      err_d = 1'b1;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fifo_q <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      count_q <= '0;
      last_q <= 1'b1;
      err_q <= 1'b0;
    end else begin
      fifo_q <= fifo_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      count_q <= count_d;
      last_q <= last_d;
      err_q <= err_d;
    end
  end

  assign ds.rq_valid = rq_vld;
  assign ds.rq_addr = gnt ? m1.rq_addr : m0.rq_addr;
  assign ds.rq_iswrite = gnt ? m1.rq_iswrite : m0.rq_iswrite;
  assign ds.rq_data = gnt ? m1.rq_data : m0.rq_data;

  assign m0.rq_ready = push & ~gnt;
  assign m1.rq_ready = push & gnt;

  assign m0.rs_valid = pop & ~head;
  assign m1.rs_valid = pop & head;
  assign m0.rs_data = ds.rs_data;
  assign m1.rs_data = ds.rs_data;

  assign inflight = count_q;
  assign err_unexpected_rs = err_q;
endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter with a queue-based owner model
// checked every cycle plus hand-computed literal expectations.
module tb_mem_req_arbiter;
  localparam int LGINFL = 1;
  localparam int DEPTH = 1 << LGINFL;

  logic clk = 1'b0;
  logic reset;
  logic [LGINFL:0] inflight;
  logic err;

  mem_req_arbiter_if m0 ();
  mem_req_arbiter_if m1 ();
  mem_req_arbiter_if ds ();

  mem_req_arbiter #(.LGINFL(LGINFL)) dut (
    .clk(clk),
    .reset(reset),
    .m0(m0),
    .m1(m1),
    .ds(ds),
    .inflight(inflight),
    .err_unexpected_rs(err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 0;

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: queue of owners in issue order, last winner, sticky error.
  bit mq[$];
  bit m_last = 1'b1;
  bit m_err = 1'b0;

  always @(negedge clk) begin
    bit v0, v1, g, can, rqv, hs, pop;
    v0 = m0.rq_valid;
    v1 = m1.rq_valid;
    g = (v0 && v1) ? !m_last : v1;
    can = (mq.size() < DEPTH) || ds.rs_valid;
    rqv = (v0 || v1) && can;
    hs = rqv && ds.rq_ready;
    pop = ds.rs_valid && (mq.size() > 0);
    if (chk_en) begin
      chk1("rq_valid", ds.rq_valid, rqv);
      if (v0 || v1) begin
        chk32("rq_addr", ds.rq_addr, g ? m1.rq_addr : m0.rq_addr);
        chk1("rq_iswrite", ds.rq_iswrite, g ? m1.rq_iswrite : m0.rq_iswrite);
        chk32("rq_data", ds.rq_data, g ? m1.rq_data : m0.rq_data);
      end
      chk1("m0_rq_ready", m0.rq_ready, hs && !g);
      chk1("m1_rq_ready", m1.rq_ready, hs && g);
      chk1("m0_rs_valid", m0.rs_valid, pop && (mq[0] == 1'b0));
      chk1("m1_rs_valid", m1.rs_valid, pop && (mq[0] == 1'b1));
      if (ds.rs_valid) begin
        chk32("m0_rs_data", m0.rs_data, ds.rs_data);
        chk32("m1_rs_data", m1.rs_data, ds.rs_data);
      end
      chk32("inflight", 32'(inflight), 32'(mq.size()));
      chk1("err", err, m_err);
    end
    if (reset) begin
      mq.delete();
      m_last = 1'b1;
      m_err = 1'b0;
    end else begin
      if (pop) void'(mq.pop_front());
      else if (ds.rs_valid) m_err = 1'b1;
      if (hs) begin
        mq.push_back(g);
        m_last = g;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic idle();
    m0.rq_valid = 0; m0.rq_addr = 0; m0.rq_iswrite = 0; m0.rq_data = 0;
    m1.rq_valid = 0; m1.rq_addr = 0; m1.rq_iswrite = 0; m1.rq_data = 0;
    ds.rq_ready = 0; ds.rs_valid = 0; ds.rs_data = 0;
  endtask

  task automatic req(input int who, input logic [31:0] a,
                     input logic w, input logic [31:0] d);
    if (who == 0) begin
      m0.rq_valid = 1; m0.rq_addr = a; m0.rq_iswrite = w; m0.rq_data = d;
    end else begin
      m1.rq_valid = 1; m1.rq_addr = a; m1.rq_iswrite = w; m1.rq_data = d;
    end
  endtask

  task automatic rsp(input logic [31:0] d);
    ds.rs_valid = 1;
    ds.rs_data = d;
  endtask

  task automatic do_reset();
    reset = 1;
    idle();
    cyc();
    reset = 0;
  endtask

  initial begin
    idle();
    reset = 1;
    cyc();
    chk_en = 1;
    samp();
    chk32("rst inflight", 32'(inflight), 32'd0);
    chk1("rst err", err, 1'b0);
    chk1("rst rq_valid", ds.rq_valid, 1'b0);
    cyc();
    reset = 0;

    // Single requester read, RAM answers next cycle
    req(0, 32'h0000_0010, 1'b0, 32'h0);
    ds.rq_ready = 1;
    samp();
    chk1("t1 rq_valid", ds.rq_valid, 1'b1);
    chk1("t1 m0 ready", m0.rq_ready, 1'b1);
    chk32("t1 addr", ds.rq_addr, 32'h0000_0010);
    chk32("t1 inflight0", 32'(inflight), 32'd0);
    cyc();
    m0.rq_valid = 0;
    rsp(32'hDEAD_BEEF);
    samp();
    chk1("t1 m0 rs_valid", m0.rs_valid, 1'b1);
    chk32("t1 m0 rs_data", m0.rs_data, 32'hDEAD_BEEF);
    chk1("t1 m1 rs_valid", m1.rs_valid, 1'b0);
    chk32("t1 inflight1", 32'(inflight), 32'd1);
    cyc();
    idle();
    samp();
    chk32("t1 inflight2", 32'(inflight), 32'd0);
    cyc();

    // Contention from reset: grants alternate starting with m0
    do_reset();
    req(0, 32'h100, 1'b0, 32'h0);
    req(1, 32'h200, 1'b0, 32'h0);
    ds.rq_ready = 1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) rsp(32'h100 + i);
      samp();
      chk1("t2 m0 grant", m0.rq_ready, (i % 2) == 0);
      chk1("t2 m1 grant", m1.rq_ready, (i % 2) == 1);
      if (i > 0) chk1("t2 m0 route", m0.rs_valid, (i % 2) == 1);
      if (i > 0) chk1("t2 m1 route", m1.rs_valid, (i % 2) == 0);
      cyc();
    end
    m0.rq_valid = 0;
    m1.rq_valid = 0;
    rsp(32'h104);
    samp();
    chk1("t2 last route", m1.rs_valid, 1'b1);
    cyc();
    idle();
    cyc();

    // Full FIFO: two issues with no responses stall the third
    do_reset();
    req(0, 32'h300, 1'b0, 32'h0);
    ds.rq_ready = 1;
    samp();
    chk1("t3 c0 rq_valid", ds.rq_valid, 1'b1);
    cyc();
    samp();
    chk32("t3 c1 inflight", 32'(inflight), 32'd1);
    cyc();
    samp();
    chk1("t3 full rq_valid", ds.rq_valid, 1'b0);
    chk32("t3 full inflight", 32'(inflight), 32'd2);
    chk1("t3 full m0 ready", m0.rq_ready, 1'b0);
    cyc();
    rsp(32'h0000_00AA);
    samp();
    chk1("t3 pop rq_valid", ds.rq_valid, 1'b1);
    chk1("t3 pop m0 ready", m0.rq_ready, 1'b1);
    chk1("t3 pop m0 rs", m0.rs_valid, 1'b1);
    cyc();
    ds.rs_valid = 0;
    samp();
    chk32("t3 still full", 32'(inflight), 32'd2);
    chk1("t3 stalled", ds.rq_valid, 1'b0);
    cyc();
    m0.rq_valid = 0;
    rsp(32'h0000_00B0);
    cyc();
    rsp(32'h0000_00B1);
    samp();
    chk32("t3 drain1", 32'(inflight), 32'd1);
    cyc();
    idle();
    samp();
    chk32("t3 drain0", 32'(inflight), 32'd0);
    cyc();

    // Mixed: m1 MMIO write answered at once, m0 RAM read behind it
    req(0, 32'h0000_0020, 1'b0, 32'h0);
    req(1, 32'h1001_200C, 1'b1, 32'hCAFE_F00D);
    ds.rq_ready = 1;
    samp();
    chk1("t4 m1 first", m1.rq_ready, 1'b1);
    chk1("t4 iswrite", ds.rq_iswrite, 1'b1);
    chk32("t4 addr", ds.rq_addr, 32'h1001_200C);
    chk32("t4 data", ds.rq_data, 32'hCAFE_F00D);
    cyc();
    m1.rq_valid = 0;
    rsp(32'h0);
    samp();
    chk1("t4 wr rs m1", m1.rs_valid, 1'b1);
    chk1("t4 wr rs m0", m0.rs_valid, 1'b0);
    chk1("t4 m0 issue", m0.rq_ready, 1'b1);
    cyc();
    m0.rq_valid = 0;
    rsp(32'h1234_5678);
    samp();
    chk1("t4 rd rs m0", m0.rs_valid, 1'b1);
    chk1("t4 rd rs m1", m1.rs_valid, 1'b0);
    chk32("t4 rd data", m0.rs_data, 32'h1234_5678);
    cyc();
    idle();
    samp();
    chk32("t4 empty", 32'(inflight), 32'd0);
    cyc();

    // Backpressure on m1
    req(1, 32'hAAAA_0004, 1'b1, 32'h0000_0055);
    ds.rq_ready = 0;
    for (int i = 0; i < 3; i++) begin
      samp();
      chk1("t5 m1 not ready", m1.rq_ready, 1'b0);
      chk1("t5 rq_valid", ds.rq_valid, 1'b1);
      chk32("t5 addr held", ds.rq_addr, 32'hAAAA_0004);
      chk32("t5 data held", ds.rq_data, 32'h0000_0055);
      cyc();
    end
    ds.rq_ready = 1;
    samp();
    chk1("t5 m1 ready", m1.rq_ready, 1'b1);
    cyc();
    m1.rq_valid = 0;
    rsp(32'h0);
    samp();
    chk1("t5 m1 rs", m1.rs_valid, 1'b1);
    cyc();
    idle();

    // Unexpected response, sticky error, reset mid-flight
    samp();
    chk1("t6 err0", err, 1'b0);
    cyc();
    rsp(32'h77);
    samp();
    chk1("t6 no m0 rs", m0.rs_valid, 1'b0);
    chk1("t6 no m1 rs", m1.rs_valid, 1'b0);
    cyc();
    idle();
    samp();
    chk1("t6 err set", err, 1'b1);
    cyc();
    req(0, 32'h40, 1'b0, 32'h0);
    ds.rq_ready = 1;
    samp();
    chk1("t6 err hold", err, 1'b1);
    cyc();
    idle();
    samp();
    chk32("t6 inflight1", 32'(inflight), 32'd1);
    cyc();
    reset = 1;
    cyc();
    reset = 0;
    samp();
    chk32("t6 rst inflight", 32'(inflight), 32'd0);
    chk1("t6 rst err", err, 1'b0);
    cyc();
    rsp(32'h88);
    cyc();
    idle();
    samp();
    chk1("t6 late rs err", err, 1'b1);
    cyc();
    do_reset();
    cyc();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
